dmem_bhw: RTL

Parametrised byte-addressable MIPS32 data memory with a valid/ready request port, configurable wait states and registered responses. It replaces the single-cycle word-indexed data memory on the MEM stage side and adds byte/halfword/word stores, sign- or zero-extended loads, and error reporting for misaligned or out-of-range accesses. The pipeline stalls on `req_ready` and consumes results on `rsp_valid`.

---
 rtl/dmem_bhw.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_bhw.sv
// Byte-addressable MIPS32 data memory behind a valid/ready request port.
// Each access takes WAIT_CYCLES+1 busy cycles and ends in a one-cycle registered response.
module dmem_bhw #(
    parameter int    ADDR_W      = 16,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept, do_access;

    logic [31:0] mem [DEPTH];

    logic        wr_p0;
    logic [1:0]  size_p0;
    logic        uns_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic [ADDR_W-3:0] idx_p0;
    logic [31:0]       word_p0;
    logic              err_p0;

    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = ((addr >> ADDR_W) != 32'd0);
        case (size)
            2'b01:   bad = bad | addr[0];
            2'b10:   bad = bad | (addr[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = bad;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] w;
        w = old;
        case (size)
            2'b00:   w[{off, 3'b000} +: 8]        = wdata[7:0];
            2'b01:   w[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default: w                            = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic [31:0]        sh_b, sh_h;
        sh_b = word >> {off, 3'b000};
        sh_h = word >> {off[1], 4'b0000};
        b8   = sh_b[7:0];
        h16  = sh_h[15:0];
        case (size)
            2'b00:   return uns ? {24'd0, b8}  : 32'(b8);
            2'b01:   return uns ? {16'd0, h16} : 32'(h16);
            default: return word;
        endcase
    endfunction

    assign req_ready = (state == IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // stage p0: request captured on accept, held through the busy window
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= req_wr;
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    assign idx_p0  = addr_p0[ADDR_W-1:2];
    assign word_p0 = mem[idx_p0];
    assign err_p0  = access_err(size_p0, addr_p0);

    // Reset gates the write so an access abandoned by reset never commits.
    always_ff @(posedge clk) begin
        if (do_access & wr_p0 & ~err_p0 & ~rst)
            mem[idx_p0] <= store_merge(word_p0, wdata_p0, size_p0, addr_p0[1:0]);
    end

    // stage p1: response registered on the access edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= do_access;
            if (do_access) begin
                rsp_err   <= err_p0;
                rsp_rdata <= (err_p0 | wr_p0) ? 32'd0
                                              : load_ext(word_p0, size_p0, addr_p0[1:0], uns_p0);
            end
        end
    end

endmodule
